// File: rtl/crypto_pkg.sv
// Shared constants and round primitives for the encrypt and decrypt engines.
package crypto_pkg;

    localparam int unsigned BLOCK_W = 32;
    localparam logic [BLOCK_W-1:0] KEY_BASE = 32'hDEADBEEF;

    typedef logic [BLOCK_W-1:0] block_t;

    // Round r mixes its index into the top byte of the base key.
    function automatic block_t round_key(input block_t base, input int unsigned r);
        return base ^ (block_t'(r) << 24);
    endfunction

    function automatic block_t rotl1(input block_t t);
        return {t[BLOCK_W-2:0], t[BLOCK_W-1]};
    endfunction

    function automatic block_t rotr1(input block_t t);
        return {t[0], t[BLOCK_W-1:1]};
    endfunction

endpackage

// File: rtl/decrypt_pipeline_if.sv
// Ciphertext-in / plaintext-out valid/ready stream pair of the decrypt pipeline.
interface decrypt_pipeline_if #(
    parameter int unsigned BLOCK_WIDTH = 32
);
    logic [BLOCK_WIDTH-1:0] data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic [BLOCK_WIDTH-1:0] data_out;
    logic                   data_out_valid;
    logic                   data_out_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/decrypt_round.sv
// One pipeline stage: applies the inverse round for ROUND_IDX and registers the result.
module decrypt_round #(
    parameter int unsigned ROUND_IDX = 0,
    parameter logic [31:0] KEY_BASE  = crypto_pkg::KEY_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  crypto_pkg::block_t in_data,
    input  logic              in_valid,
    output crypto_pkg::block_t out_data,
    output logic              out_valid
);
    import crypto_pkg::*;

    localparam block_t RKEY = round_key(KEY_BASE, ROUND_IDX);

    block_t data_q, data_d;
    logic   valid_q, valid_d;

    // NOTE: every variable gets its hold value first, so no path through the block can infer a latch.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (advance) begin
            data_d  = rotr1(in_data) ^ RKEY;
            valid_d = in_valid;
        end
    end

    // NOTE: state registers use non-blocking assignments and clear on the asynchronous reset edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/decrypt_pipeline.sv
// Fully pipelined inverse cipher, one inverse round per stage, with throughput counters.
module decrypt_pipeline #(
    parameter int unsigned BLOCK_WIDTH   = 32,
    parameter int unsigned ROUNDS        = 8,
    parameter logic [31:0] KEY_BASE      = crypto_pkg::KEY_BASE,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    decrypt_pipeline_if.slave        dif,
    output logic [COUNTER_WIDTH-1:0] blocks_processed,
    output logic [COUNTER_WIDTH-1:0] cycles_elapsed
);
    import crypto_pkg::*;

    logic [ROUNDS:0][BLOCK_WIDTH-1:0] chain_data;
    logic [ROUNDS:0]                  chain_valid;
    logic                             advance;
    logic                             in_fire;
    logic                             out_fire;

    // A single global enable: the whole pipe shifts or the whole pipe holds, bubbles included.
    assign advance           = !chain_valid[ROUNDS] || dif.data_out_ready;
    assign in_fire           = dif.data_in_valid && advance;
    assign out_fire          = chain_valid[ROUNDS] && dif.data_out_ready;

    assign chain_data[0]     = dif.data_in;
    assign chain_valid[0]    = dif.data_in_valid;
    assign dif.data_in_ready = advance;
    assign dif.data_out      = chain_data[ROUNDS];
    assign dif.data_out_valid = chain_valid[ROUNDS];

    // Stage s undoes encrypt round ROUNDS-1-s, so the last encrypt round is peeled off first.
    for (genvar s = 0; s < ROUNDS; s++) begin : g_stage
        decrypt_round #(
            .ROUND_IDX (ROUNDS - 1 - s),
            .KEY_BASE  (KEY_BASE)
        ) u_round (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_data   (chain_data[s]),
            .in_valid  (chain_valid[s]),
            .out_data  (chain_data[s+1]),
            .out_valid (chain_valid[s+1])
        );
    end

    logic                     active_q, active_d;
    logic [COUNTER_WIDTH-1:0] blocks_q, blocks_d;
    logic [COUNTER_WIDTH-1:0] cycles_q, cycles_d;

    always_comb begin
        active_d = active_q || in_fire;
        blocks_d = blocks_q;
        cycles_d = cycles_q;
        if (out_fire) begin
            blocks_d = blocks_q + COUNTER_WIDTH'(1);
        end
        // Counting starts the cycle after the first accept, since active_q is still low on that edge.
        if (active_q) begin
            cycles_d = cycles_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            blocks_q <= '0;
            cycles_q <= '0;
        end else begin
            active_q <= active_d;
            blocks_q <= blocks_d;
            cycles_q <= cycles_d;
        end
    end

    assign blocks_processed = blocks_q;
    assign cycles_elapsed   = cycles_q;

endmodule
